// File: rtl/gate_test_ctrl.sv
// Gate-level functional tester: walks every input vector of a small combinational
// gate, waits a settle time, samples its output and tallies mismatches against a truth table.
module gate_test_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   tt,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_fail
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [3:0]      LAST_SETTLE = 4'(SETTLE - 1);

  logic [2:0]          state;
  logic [2**N_IN-1:0]  tt_q;
  logic [N_IN-1:0]     vec;
  logic [3:0]          settle_cnt;
  logic                mismatch;

  always_comb begin
    mismatch = (dut_out != tt_q[vec]);
    busy     = (state != S_IDLE);
    done     = (state == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tt_q       <= '0;
      vec        <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (abort && (state != S_IDLE)) begin
      // Partial err_cnt/first_fail are kept so a cancelled run can still be inspected
      state      <= S_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            tt_q       <= tt;
            err_cnt    <= '0;
            pass       <= 1'b0;
            first_fail <= '0;
            vec        <= '0;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          dut_in     <= vec;
          settle_cnt <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (settle_cnt == LAST_SETTLE) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + (N_IN+1)'(1);
            if (err_cnt == '0) begin
              first_fail <= vec;
            end
          end
          if (vec == LAST_VEC) begin
            dut_in <= '0;
            state  <= S_FINISH;
          end else begin
            vec   <= vec + N_IN'(1);
            state <= S_APPLY;
          end
        end
        S_FINISH: begin
          pass  <= (err_cnt == '0);
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_test_ctrl.md
GATE_TEST_CTRL -- requirements
Module: gate_test_ctrl

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, giving the gate-under-test input count (legal range 1..4).
REQ-002 The block SHALL have parameter SETTLE, default 2, giving the settle cycles per vector before sampling (legal range 1..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 START  in  1  begin a test run; sampled only in IDLE.
REQ-007 ABORT  in  1  synchronous cancel of a run in progress.
REQ-008 TT  in  2**N_IN  expected truth table; bit k is the expected gate output for input vector k.
REQ-009 DUT_IN  out  N_IN  registered stimulus vector driven to the gate under test.
REQ-010 DUT_OUT  in  1  gate-under-test output.
REQ-011 BUSY  out  1  high in every state except IDLE.
REQ-012 DONE  out  1  one-cycle pulse at run completion.
REQ-013 PASS  out  1  high when the last completed run had zero mismatches.
REQ-014 ERR_CNT  out  N_IN+1  mismatch count of the current or last run.
REQ-015 FIRST_FAIL  out  N_IN  vector index of the first mismatch in the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, WAIT, SAMPLE and FINISH.
REQ-017 In IDLE with START=1, at the clock edge: latch TT into TT_q, clear ERR_CNT, PASS and FIRST_FAIL, set vector counter to 0, go to APPLY.
REQ-018 APPLY (1 cycle): DUT_IN is loaded with the vector counter; go to WAIT.
REQ-019 WAIT: hold DUT_IN for exactly SETTLE cycles via a settle counter; then go to SAMPLE.
REQ-020 SAMPLE (1 cycle): if DUT_OUT != TT_q[vector], increment ERR_CNT; on the first mismatch of the run, also load FIRST_FAIL with the vector.
REQ-021 SAMPLE exit: if vector = 2**N_IN-1, go to FINISH; otherwise increment the vector and go to APPLY.
REQ-022 Each vector SHALL take exactly SETTLE+2 cycles.
REQ-023 FINISH (1 cycle): DONE=1; PASS <= (no mismatch in the run, including the final SAMPLE); go to IDLE.
REQ-024 DONE SHALL be high only during the cycle that begins 2**N_IN*(SETTLE+2) rising edges after the START-sampling edge.
REQ-025 DUT_IN SHALL be 0 in IDLE and FINISH.
REQ-026 START SHALL be ignored while BUSY=1; a START held high re-arms a new run on the cycle after FINISH.
REQ-027 Changes to TT during a run SHALL NOT affect the run; only TT_q is used.
REQ-028 ABORT=1 in any non-IDLE state SHALL force IDLE at the next edge.
REQ-029 On abort: DONE is not asserted, PASS=0, ERR_CNT and FIRST_FAIL hold their partial values, DUT_IN goes to 0.
REQ-030 ABORT and START high together in IDLE SHALL give ABORT priority: no run starts.
REQ-031 ERR_CNT SHALL NOT wrap; its maximum value 2**N_IN fits in N_IN+1 bits.
REQ-032 ERR_CNT, PASS and FIRST_FAIL SHALL hold their values in IDLE until the next accepted START.

Reset
REQ-033 RST_N=0 SHALL immediately force IDLE, with DUT_IN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, TT_q=0, and all counters at 0.
REQ-034 Reset asserted mid-run SHALL discard the run with no DONE pulse.
REQ-035 The first START is accepted on the first rising edge after RST_N deasserts.

Verification
REQ-036 Inverter, N_IN=1, SETTLE=1, TT=2'b01, with a correct inverter model -> DUT_IN sequence 0 then 1, DONE pulse 6 edges after START, PASS=1, ERR_CNT=0.
REQ-037 AND2, N_IN=2, SETTLE=2, TT=4'b1000, model output stuck at 1 -> DONE 16 edges after START, PASS=0, ERR_CNT=3, FIRST_FAIL=0.
REQ-038 N_IN=2, TT=4'b1000 with an OR-gate model -> ERR_CNT=2 and FIRST_FAIL=1; TT changed to 4'b0000 mid-run -> result unchanged.
REQ-039 ABORT pulsed during the second vector's WAIT -> IDLE next cycle, no DONE, PASS=0, DUT_IN=0; the next START runs normally.
REQ-040 RST_N pulsed low mid-run -> all outputs 0 asynchronously; START held high through the run -> the second run starts the cycle after FINISH; START during BUSY is otherwise ignored.
